// File: rtl/dram_pkg.sv
// Shared DRAM controller definitions: refresh FSM encoding, default timing
// constants and the bank count used by the refresh engine, sm and the
// address mux.
package dram_pkg;

    localparam int NUM_BANKS = 4;
    localparam int TIMER_W   = 12;   // holds intervals up to 4095 cycles
    localparam int PEND_W    = 3;    // owed-refresh count up to 7

    // Default refresh timing for a 25 MHz bus clock.
    localparam int DEF_REFRESH_INTERVAL = 390;   // 15.6 us
    localparam int DEF_MAX_PENDING      = 4;
    localparam int DEF_T_CSR            = 1;
    localparam int DEF_T_RAS            = 3;
    localparam int DEF_T_RP             = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CSR  = 2'd1,
        RAS  = 2'd2,
        PRE  = 2'd3
    } refState_e;

    // Largest of three cycle counts; sizes the per-state phase counter.
    function automatic int maxOf3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/dram_ref_timer.sv
// Interval down-counter with a one-cycle tick. Also intended for the
// power-on DRAM init delay, so it knows nothing about refresh itself.
module dram_ref_timer
    import dram_pkg::*;
#(
    parameter int INTERVAL = DEF_REFRESH_INTERVAL
) (
    input  logic clk,
    input  logic nRESET,
    input  logic en,
    output logic tick
);

    localparam logic [TIMER_W-1:0] RELOAD = TIMER_W'(INTERVAL - 1);

    logic [TIMER_W-1:0] count;

    // Tick lasts exactly the cycle in which the enabled count reads zero.
    assign tick = en && (count == '0);

    // Count down while enabled; park at the reload value when disabled.
    always_ff @(posedge clk or negedge nRESET) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!nRESET) begin
            count <= RELOAD;
        end else if (!en || tick) begin
            count <= RELOAD;
        end else begin
            count <= count - TIMER_W'(1);
        end
    end

endmodule

// File: rtl/dram_refresh.sv
// CAS-before-RAS refresh engine. Tracks owed refreshes, requests the bus
// from sm and, once granted, drives its own refresh strobes.
module dram_refresh
    import dram_pkg::*;
#(
    parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
    parameter int MAX_PENDING      = DEF_MAX_PENDING,
    parameter int T_CSR            = DEF_T_CSR,
    parameter int T_RAS            = DEF_T_RAS,
    parameter int T_RP             = DEF_T_RP
) (
    input  logic                 clk,
    input  logic                 nRESET,
    input  logic                 ref_en,
    input  logic                 ref_gnt,
    output logic                 ref_req,
    output logic                 ref_busy,
    output logic                 ref_done,
    output logic [NUM_BANKS-1:0] nRAS_ref,
    output logic                 nCAS_ref,
    output logic [PEND_W-1:0]    pending,
    output logic                 overflow
);

    localparam int CNT_MAX = maxOf3(T_CSR, T_RAS, T_RP);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  CSR_LOAD = CNT_W'(T_CSR - 1);
    localparam logic [CNT_W-1:0]  RAS_LOAD = CNT_W'(T_RAS - 1);
    localparam logic [CNT_W-1:0]  RP_LOAD  = CNT_W'(T_RP - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

    refState_e        state;
    logic [CNT_W-1:0] phaseCnt;
    logic             tick;
    logic             grantOk;

    dram_ref_timer #(
        .INTERVAL (REFRESH_INTERVAL)
    ) refTimer (
        .clk    (clk),
        .nRESET (nRESET),
        .en     (ref_en),
        .tick   (tick)
    );

    // A grant only counts when idle with refresh owed; all others are ignored.
    assign grantOk = ref_gnt && (state == IDLE) && (pending != '0);

    // NOTE: request is decoded from registers only, so ref_gnt never loops back into it.
    assign ref_req = (state == IDLE) && (pending != '0);

    // Owed-refresh counter with saturation and a sticky overflow flag.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else if (!ref_en) begin
            pending <= '0;
        end else if (tick && !grantOk) begin
            if (pending == PEND_MAX) begin
                overflow <= 1'b1;
            end else begin
                pending <= pending + PEND_W'(1);
            end
        end else if (grantOk && !tick) begin
            pending <= pending - PEND_W'(1);
        end
    end

    // Refresh sequencer: CSR -> RAS -> PRE, strobes and status registered.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            phaseCnt <= '0;
            ref_busy <= 1'b0;
            ref_done <= 1'b0;
            nRAS_ref <= '1;
            nCAS_ref <= 1'b1;
        end else begin
            // NOTE: every state is handled and default recovers to IDLE, so no state can hang.
            case (state)
                IDLE: begin
                    if (grantOk) begin
                        state    <= CSR;
                        phaseCnt <= CSR_LOAD;
                        ref_busy <= 1'b1;
                        nCAS_ref <= 1'b0;
                    end
                end
                CSR: begin
                    if (phaseCnt == '0) begin
                        state    <= RAS;
                        phaseCnt <= RAS_LOAD;
                        nRAS_ref <= '0;
                    end else begin
                        phaseCnt <= phaseCnt - CNT_W'(1);
                    end
                end
                RAS: begin
                    if (phaseCnt == '0) begin
                        state    <= PRE;
                        phaseCnt <= RP_LOAD;
                        nRAS_ref <= '1;
                        nCAS_ref <= 1'b1;
                        ref_done <= (T_RP == 1);
                    end else begin
                        phaseCnt <= phaseCnt - CNT_W'(1);
                    end
                end
                PRE: begin
                    if (phaseCnt == '0) begin
                        state    <= IDLE;
                        ref_busy <= 1'b0;
                        ref_done <= 1'b0;
                    end else begin
                        phaseCnt <= phaseCnt - CNT_W'(1);
                        ref_done <= (phaseCnt == CNT_W'(1));
                    end
                end
                default: begin
                    state    <= IDLE;
                    ref_busy <= 1'b0;
                    ref_done <= 1'b0;
                    nRAS_ref <= '1;
                    nCAS_ref <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_refresh.sv
// Self-checking bench for dram_refresh: a cycle model of the refresh engine
// pushes the expected outputs for each driven cycle onto a queue, which is
// popped and compared once the DUT has clocked that cycle. Directed checks
// against fixed values cover the key points of each scenario.
module tb_dram_refresh;

    localparam int INTERVAL = 16;
    localparam int MAXP     = 4;
    localparam int TCSR     = 1;
    localparam int TRAS     = 3;
    localparam int TRP      = 2;
    localparam int SEQ_LEN  = TCSR + TRAS + TRP;

    // {req, busy, done, nRAS[3:0], nCAS, pending[2:0], overflow}
    localparam logic [11:0] RST_VAL = {1'b0, 1'b0, 1'b0, 4'hF, 1'b1, 3'd0, 1'b0};

    logic       clk = 1'b0;
    logic       nRESET = 1'b1;
    logic       ref_en = 1'b0;
    logic       ref_gnt = 1'b0;
    logic       ref_req;
    logic       ref_busy;
    logic       ref_done;
    logic [3:0] nRAS_ref;
    logic       nCAS_ref;
    logic [2:0] pending;
    logic       overflow;

    dram_refresh #(
        .REFRESH_INTERVAL (INTERVAL),
        .MAX_PENDING      (MAXP),
        .T_CSR            (TCSR),
        .T_RAS            (TRAS),
        .T_RP             (TRP)
    ) dut (
        .clk      (clk),
        .nRESET   (nRESET),
        .ref_en   (ref_en),
        .ref_gnt  (ref_gnt),
        .ref_req  (ref_req),
        .ref_busy (ref_busy),
        .ref_done (ref_done),
        .nRAS_ref (nRAS_ref),
        .nCAS_ref (nCAS_ref),
        .pending  (pending),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int assertCount = 0;
    int failCount   = 0;

    // Model state: timer value, owed count, sticky flag, position in sequence (0 = idle).
    int mTimer;
    int mPend;
    bit mOvf;
    int mSeq;

    logic [11:0] expQ[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [11:0] dutOut();
        return {ref_req, ref_busy, ref_done, nRAS_ref, nCAS_ref, pending, overflow};
    endfunction

    function automatic logic [11:0] modelOut();
        logic       req;
        logic       busy;
        logic       done;
        logic       nCas;
        logic [3:0] nRas;
        busy = (mSeq != 0);
        nCas = !(mSeq >= 1 && mSeq <= TCSR + TRAS);
        nRas = (mSeq > TCSR && mSeq <= TCSR + TRAS) ? 4'h0 : 4'hF;
        done = (mSeq == SEQ_LEN);
        req  = (mSeq == 0) && (mPend != 0);
        return {req, busy, done, nRas, nCas, 3'(mPend), mOvf};
    endfunction

    task automatic modelReset();
        mTimer = INTERVAL - 1;
        mPend  = 0;
        mOvf   = 1'b0;
        mSeq   = 0;
    endtask

    task automatic modelStep(input bit en, input bit gnt);
        bit tick;
        bit acc;
        tick = en && (mTimer == 0);
        acc  = gnt && (mSeq == 0) && (mPend != 0);
        if (!en) mPend = 0;
        else if (tick && !acc) begin
            if (mPend == MAXP) mOvf = 1'b1;
            else mPend++;
        end else if (acc && !tick) mPend--;
        if (!en || tick) mTimer = INTERVAL - 1;
        else mTimer--;
        if (acc) mSeq = 1;
        else if (mSeq == SEQ_LEN) mSeq = 0;
        else if (mSeq != 0) mSeq++;
    endtask

    // Drive one cycle of stimulus, queue its expected result, clock and compare.
    task automatic runCycle(input bit en, input bit gnt);
        logic [11:0] expVal;
        ref_en  = en;
        ref_gnt = gnt;
        modelStep(en, gnt);
        expQ.push_back(modelOut());
        @(posedge clk);
        #1;
        expVal = expQ.pop_front();
        check("cycle", 32'(dutOut()), 32'(expVal));
    endtask

    // Run with ref_en high through the next tick cycle.
    task automatic runUntilTick();
        for (int i = 0; i < INTERVAL + 2 && mTimer != 0; i++) runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        modelReset();
        #1 nRESET = 1'b0;
        repeat (3) @(posedge clk);
        #1 nRESET = 1'b1;
        check("reset_state", 32'(dutOut()), 32'(RST_VAL));

        // Disabled: no ticks, nothing owed.
        repeat (4) runCycle(1'b0, 1'b0);

        // Basic interval: tick in cycle 15, pending visible from cycle 16.
        repeat (15) runCycle(1'b1, 1'b0);
        check("basic_no_early", 32'({ref_req, pending}), 32'({1'b0, 3'd0}));
        runCycle(1'b1, 1'b0);
        check("basic_first_tick", 32'({ref_req, pending}), 32'({1'b1, 3'd1}));

        // Single refresh, grant at cycle k.
        runCycle(1'b1, 1'b1);
        check("single_k1_csr", 32'({ref_busy, nCAS_ref, nRAS_ref, pending}), 32'({1'b1, 1'b0, 4'hF, 3'd0}));
        runCycle(1'b1, 1'b0);
        check("single_k2_ras", 32'({nCAS_ref, nRAS_ref}), 32'({1'b0, 4'h0}));
        repeat (3) runCycle(1'b1, 1'b0);
        check("single_k5_pre", 32'({ref_busy, ref_done, nCAS_ref, nRAS_ref}), 32'({1'b1, 1'b0, 1'b1, 4'hF}));
        runCycle(1'b1, 1'b0);
        check("single_k6_done", 32'({ref_busy, ref_done}), 32'({1'b1, 1'b1}));
        runCycle(1'b1, 1'b0);
        check("single_k7_idle", 32'({ref_busy, ref_done}), 32'({1'b0, 1'b0}));

        // Spurious grant with nothing owed.
        runCycle(1'b1, 1'b1);
        check("spur_nopend", 32'({ref_busy, nCAS_ref, pending}), 32'({1'b0, 1'b1, 3'd0}));

        // Grant aligned with the tick cycle while one refresh is owed.
        runUntilTick();
        for (int i = 0; i < INTERVAL + 2 && mTimer != 0; i++) runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b1);
        check("simul_pend", 32'({pending, ref_busy, ref_req}), 32'({3'd1, 1'b1, 1'b0}));
        repeat (6) runCycle(1'b1, 1'b0);
        check("simul_req_back", 32'({ref_busy, ref_req}), 32'({1'b0, 1'b1}));

        // Spurious grant during RAS.
        runCycle(1'b1, 1'b1);
        runCycle(1'b1, 1'b0);
        runCycle(1'b1, 1'b1);
        check("spur_ras", 32'({nRAS_ref, nCAS_ref, pending, ref_busy}), 32'({4'h0, 1'b0, 3'd0, 1'b1}));
        repeat (4) runCycle(1'b1, 1'b0);
        check("spur_ras_after", 32'({ref_busy, pending}), 32'({1'b0, 3'd0}));

        // Saturation and sticky overflow.
        repeat (4) runUntilTick();
        check("sat_four", 32'({overflow, pending}), 32'({1'b0, 3'd4}));
        runUntilTick();
        check("sat_overflow", 32'({overflow, pending}), 32'({1'b1, 3'd4}));

        // Drain with grant held high: back-to-back refreshes.
        for (int i = 0; i < 300 && !(mPend == 0 && mSeq == 0); i++) runCycle(1'b1, 1'b1);
        check("drain", 32'({overflow, pending, ref_busy}), 32'({1'b1, 3'd0, 1'b0}));

        // Disable during CSR: sequence completes, then stays quiet.
        runUntilTick();
        runCycle(1'b1, 1'b1);
        runCycle(1'b0, 1'b0);
        repeat (4) runCycle(1'b0, 1'b0);
        check("dis_done", 32'({ref_done, pending}), 32'({1'b1, 3'd0}));
        repeat (40) runCycle(1'b0, 1'b0);
        check("dis_quiet", 32'({ref_req, pending, ref_busy}), 32'({1'b0, 3'd0, 1'b0}));

        // Asynchronous reset during RAS.
        runUntilTick();
        runCycle(1'b1, 1'b1);
        runCycle(1'b1, 1'b0);
        check("rst_pre_ras", 32'(nRAS_ref), 32'(4'h0));
        #2 nRESET = 1'b0;
        #1;
        check("rst_async", 32'(dutOut()), 32'(RST_VAL));
        modelReset();
        @(posedge clk);
        #1;
        check("rst_hold", 32'(dutOut()), 32'(RST_VAL));
        nRESET = 1'b1;
        repeat (15) runCycle(1'b1, 1'b0);
        check("rst_restart_early", 32'(pending), 32'(3'd0));
        runCycle(1'b1, 1'b0);
        check("rst_restart_tick", 32'({ref_req, pending}), 32'({1'b1, 3'd1}));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dram_refresh.md
Name: dram_refresh

Overview:
- CAS-before-RAS refresh engine for the 68040 DRAM controller. It sits beside the main DRAM timing state machine (sm) and feeds it.
- A programmable interval timer accumulates owed refreshes. The block raises a request to sm and waits for a grant while the bus is idle.
- On grant it drives its own RAS/CAS refresh strobes. sm selects these strobes onto the nRASx/nCASxy pins while ref_busy is high.

Parameters:
- REFRESH_INTERVAL, 390, clk cycles between refresh ticks (15.6 us at 25 MHz); legal range 8..4095.
- MAX_PENDING, 4, saturation limit of the owed-refresh counter (1..7).
- T_CSR, 1, cycles nCAS_ref is low before nRAS_ref falls (>=1).
- T_RAS, 3, cycles nRAS_ref is low (>=1).
- T_RP, 2, RAS precharge cycles after the strobes rise (>=1).

Ports:
- clk  input  1  system clock, rising-edge.
- nRESET  input  1  asynchronous, active-low reset.
- ref_en  input  1  refresh enable; set high by software/boot once DRAM is initialised.
- ref_gnt  input  1  one-cycle grant from sm; sm issues it only when no 68040 DRAM cycle is active.
- ref_req  output  1  refresh requested.
- ref_busy  output  1  refresh sequence in progress; sm muxes the strobes and holds off nTS handling while high.
- ref_done  output  1  one-cycle pulse on the last precharge cycle.
- nRAS_ref  output  4  RAS strobes for banks 0-3, all driven together.
- nCAS_ref  output  1  common CAS strobe; sm fans it out to all 16 nCAS pins.
- pending  output  3  owed-refresh count.
- overflow  output  1  sticky flag: a tick arrived while pending == MAX_PENDING.

Behaviour:
- Reset, asynchronous on nRESET low:
  - timer = REFRESH_INTERVAL-1, pending = 0, overflow = 0, state = IDLE.
  - Outputs: ref_req = 0, ref_busy = 0, ref_done = 0, nRAS_ref = 4'hF, nCAS_ref = 1.
  - A reset mid-sequence releases the strobes immediately; no partial-cycle completion.
- Timer:
  - While ref_en = 1, it decrements every cycle.
  - When timer == 0, it asserts the internal tick for that cycle and reloads REFRESH_INTERVAL-1.
  - The first tick occurs REFRESH_INTERVAL cycles after ref_en rises.
  - While ref_en = 0, the timer is held at REFRESH_INTERVAL-1 and pending is cleared. A sequence already in progress still completes.
- Pending counter:
  - +1 on tick, -1 on an accepted grant.
  - Tick and accepted grant in the same cycle: pending is unchanged.
  - Tick with pending == MAX_PENDING and no accepted grant: pending stays, overflow is set. overflow is cleared only by reset.
- ref_req = (pending != 0) && state == IDLE. It is derived only from registers, with no combinational path from ref_gnt.
- Grant acceptance:
  - ref_gnt is accepted only when state == IDLE and pending != 0.
  - Any other grant is ignored, with no state change.
- FSM states and transitions; a per-state down-counter sized for the largest parameter counts the cycles in each state:
  - IDLE: strobes high. Accepted grant at edge k moves to CSR at k+1.
  - CSR: nCAS_ref = 0, nRAS_ref = F, for T_CSR cycles, then RAS.
  - RAS: nCAS_ref = 0, nRAS_ref = 0, for T_RAS cycles, then PRE.
  - PRE: nCAS_ref = 1, nRAS_ref = F, for T_RP cycles. ref_done = 1 in the final PRE cycle, then IDLE.
- ref_busy = 1 in CSR, RAS and PRE.
- Back-to-back refreshes: the earliest re-grant is accepted in the first IDLE cycle after PRE. Minimum refresh period is T_CSR+T_RAS+T_RP+1 cycles.
- All outputs are registered or decoded from state registers only: glitch-free strobes, with no combinational path from inputs to outputs.

Decomposition:
- Shared package dram_pkg:
  - FSM state encoding (IDLE, CSR, RAS, PRE).
  - Default timing constants: REFRESH_INTERVAL, T_CSR, T_RAS, T_RP.
  - Bank count of 4, shared with sm and the address mux.
- One natural sub-module, dram_ref_timer: the interval down-counter plus tick generation, reused later for the power-on DRAM init delay.
- FSM and pending logic stay in dram_refresh.

Test Plan:
- Basic interval. REFRESH_INTERVAL=16, release reset, ref_en=1 at cycle 0 -> tick at cycle 15, pending=1 and ref_req=1 from cycle 16; nothing earlier.
- Single refresh. With pending=1, pulse ref_gnt at cycle k ->
  - k+1: nCAS_ref=0.
  - k+2..k+4: nRAS_ref=0.
  - k+5..k+6: strobes high.
  - ref_done pulses at k+6, ref_busy=1 over k+1..k+6, pending=0 at k+1.
- Saturation. Withhold ref_gnt for 5 intervals -> pending=4 after the 4th tick; overflow=1 after the 5th, pending stays 4; grants then drain to 0, overflow stays 1.
- Simultaneous tick and grant. Align ref_gnt with the timer==0 cycle while pending=1 -> pending stays 1, sequence starts, ref_req=0 during busy and 1 again in IDLE.
- Spurious grant. ref_gnt while pending=0, and ref_gnt during RAS -> no state change, no extra decrement, strobes unaffected.
- Reset and disable mid-operation.
  - nRESET low during RAS -> nRAS_ref=F and nCAS_ref=1 asynchronously, all counters at reset values.
  - ref_en=0 during CSR -> sequence finishes with ref_done, pending=0, no further ticks.
